// File: rtl/cla_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial CLA add/subtract controller.
package cla_serial_adder_ctrl_pkg;

  // Width of one CLA pass.
  localparam int unsigned NibW = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/carry_lookahead_4bit.sv
// 4-bit carry-lookahead adder slice: S = X + Y + Cin, Cout = carry out of bit 3.
module carry_lookahead_4bit (
  output logic       Cout,
  output logic [3:0] S,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       Cin
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Generate/propagate terms and flattened lookahead carries.
  always_comb begin
    g    = X & Y;
    p    = X ^ Y;
    c[0] = Cin;
    c[1] = g[0] | (p[0] & Cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
           (p[3] & p[2] & p[1] & p[0] & Cin);
    S    = p ^ c[3:0];
    Cout = c[4];
  end

endmodule

// File: rtl/cla_serial_adder_ctrl.sv
// Nibble-serial WIDTH-bit add/subtract around one 4-bit CLA, LSB nibble first,
// with valid/ready handshakes on operand and result sides.
module cla_serial_adder_ctrl
  import cla_serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NIBBLES = WIDTH / NibW;
  localparam int unsigned CntW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  if ((WIDTH % NibW) != 0 || WIDTH < NibW) begin : g_width_check
    $error("WIDTH must be a positive multiple of 4");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, b_sh_q, sum_sh_q, sum_next;
  logic [CntW-1:0]   cnt_q;
  logic              carry_q, a_msb_q, b_msb_q;
  logic [WIDTH-1:0]  sum_q;
  logic              cout_q, ovf_q;
  logic [NibW-1:0]   cla_s;
  logic              cla_cout;
  logic              accept, last;

  carry_lookahead_4bit u_cla (
    .Cout (cla_cout),
    .S    (cla_s),
    .X    (a_sh_q[NibW-1:0]),
    .Y    (b_sh_q[NibW-1:0]),
    .Cin  (carry_q)
  );

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign accept    = in_valid && in_ready;
  assign last      = (state_q == StRun) && (cnt_q == CntW'(NIBBLES - 1));

  // Partial result shifted right one nibble with the new CLA nibble on top.
  always_comb begin
    sum_next                   = sum_sh_q >> NibW;
    sum_next[WIDTH-1 -: NibW]  = cla_s;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Operand/result shifters, carry register and held outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1.
      a_sh_q  <= a;
      b_sh_q  <= sub ? ~b : b;
      carry_q <= sub ? 1'b1 : cin;
      cnt_q   <= '0;
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
    end else if (state_q == StRun) begin
      a_sh_q   <= a_sh_q >> NibW;
      b_sh_q   <= b_sh_q >> NibW;
      sum_sh_q <= sum_next;
      carry_q  <= cla_cout;
      cnt_q    <= cnt_q + CntW'(1);
      if (last) begin
        sum_q  <= sum_next;
        cout_q <= cla_cout;
        ovf_q  <= (a_msb_q == b_msb_q) && (sum_next[WIDTH-1] != a_msb_q);
      end
    end
  end

endmodule
